// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and sizing helper for the memory arbiter
// Contents: FSM state encoding, transaction owner encoding, line-offset width helper.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    // byte-offset bits within one line of 'burst' 16-bit words; also wide enough to count 0..burst
    function automatic int line_off_w(input int burst);
        return $clog2(burst) + 1;
    endfunction
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: D-priority decision with a streak limit so fetch is never starved
// Ports: clk, rst (sync, active-low), i_req/d_req requests, gnt strobe (a grant is
// being made this cycle), pick_i/pick_d mutually exclusive winner.
module mem_arb_pick #(
    parameter int MAX_D_STREAK = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    input  logic gnt,
    output logic pick_i,
    output logic pick_d
);
    localparam int SW = $clog2(MAX_D_STREAK + 1);
    logic [SW-1:0] streak_q, streak_d;
    always_ff @(posedge clk) begin
        if (!rst) streak_q <= '0;
        else      streak_q <= streak_d;
    end
    // the streak only grows while I is waiting, so it never passes the limit
    always_comb begin
        pick_d   = d_req && !(i_req && streak_q == SW'(MAX_D_STREAK));
        pick_i   = i_req && !pick_d;
        streak_d = !gnt ? streak_q : (pick_d && i_req) ? streak_q + 1'b1 : '0;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory port between I-cache fills and D-cache fills/writebacks
// Ports: clk, rst (sync, active-low); I side i_req/i_addr -> i_gnt/i_rvalid/i_rdata/i_done;
// D side d_req/d_wr/d_addr/d_wdata -> d_wready/d_gnt/d_rvalid/d_rdata/d_done;
// memory mem_en/mem_wr/mem_addr/mem_wdata out, mem_stall/mem_rvalid/mem_rdata in; busy;
// i_gnt_cnt/d_gnt_cnt/conflict_cnt are live only when MEM_ARB_PERF_CNT_EN is defined.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int BURST        = 4,
    parameter int MAX_D_STREAK = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_wready,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_stall,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [15:0]       i_gnt_cnt,
    output logic [15:0]       d_gnt_cnt,
    output logic [15:0]       conflict_cnt
);
    localparam int CNT_W = line_off_w(BURST);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'((1 << CNT_W) - 1);
    state_t state_q, state_d;
    owner_t owner_q, owner_d;
    logic wr_q, wr_d, gnt_q, gnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [CNT_W-1:0] issue_q, issue_d, ret_q, ret_d, ret_sum;
    logic pick_i, pick_d, grant, fwd, own_i, in_issue;
    mem_arb_pick #(.MAX_D_STREAK(MAX_D_STREAK)) u_pick (
        .clk(clk), .rst(rst), .i_req(i_req), .d_req(d_req),
        .gnt(grant), .pick_i(pick_i), .pick_d(pick_d)
    );
    assign grant    = state_q == IDLE && (pick_i || pick_d);
    assign in_issue = state_q == ISSUE;
    // returns outside ISSUE/DRAIN belong to no live transaction (e.g. in flight across reset)
    assign fwd      = mem_rvalid && (in_issue || state_q == DRAIN);
    assign ret_sum  = ret_q + CNT_W'(fwd);
    assign own_i    = owner_q == OWN_I;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            wr_q    <= 1'b0;
            gnt_q   <= 1'b0;
            base_q  <= '0;
            issue_q <= '0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            gnt_q   <= gnt_d;
            base_q  <= base_d;
            issue_q <= issue_d;
            ret_q   <= ret_d;
        end
    end
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        base_d  = base_q;
        issue_d = issue_q;
        ret_d   = ret_sum;
        gnt_d   = grant;
        case (state_q)
            IDLE: if (grant) begin
                state_d = ISSUE;
                owner_d = pick_d ? OWN_D : OWN_I;
                wr_d    = pick_d && d_wr;
                base_d  = (pick_d ? d_addr : i_addr) & ALIGN;
                issue_d = '0;
                ret_d   = '0;
            end
            ISSUE: if (!mem_stall) begin
                issue_d = issue_q + 1'b1;
                // a read whose returns all arrived during issue skips DRAIN
                if (issue_q == CNT_W'(BURST - 1))
                    state_d = (wr_q || ret_sum == CNT_W'(BURST)) ? DONE : DRAIN;
            end
            DRAIN: if (ret_sum == CNT_W'(BURST)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    assign i_gnt     = gnt_q && own_i;
    assign d_gnt     = gnt_q && !own_i;
    assign i_rvalid  = fwd && own_i;
    assign d_rvalid  = fwd && !own_i;
    assign i_rdata   = i_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid ? mem_rdata : '0;
    assign i_done    = state_q == DONE && own_i;
    assign d_done    = state_q == DONE && !own_i;
    assign mem_en    = in_issue;
    assign mem_wr    = in_issue && wr_q;
    assign mem_addr  = in_issue ? base_q + ADDR_W'({issue_q, 1'b0}) : '0;
    assign mem_wdata = mem_wr ? d_wdata : '0;
    assign d_wready  = mem_wr && !mem_stall;
    assign busy      = state_q != IDLE;
`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] ig_q, dg_q, cf_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            ig_q <= '0;
            dg_q <= '0;
            cf_q <= '0;
        end else begin
            if (grant && pick_i && ig_q != 16'hFFFF) ig_q <= ig_q + 1'b1;
            if (grant && pick_d && dg_q != 16'hFFFF) dg_q <= dg_q + 1'b1;
            if (state_q == IDLE && i_req && d_req && cf_q != 16'hFFFF) cf_q <= cf_q + 1'b1;
        end
    end
    assign i_gnt_cnt    = ig_q;
    assign d_gnt_cnt    = dg_q;
    assign conflict_cnt = cf_q;
`else
    assign i_gnt_cnt    = '0;
    assign d_gnt_cnt    = '0;
    assign conflict_cnt = '0;
`endif
endmodule
